// File: rtl/puf_session_ctrl.sv
// PUF session controller: fetches a challenge over SPI, runs the PUF, validates the
// response, copies it into SPRAM byte by byte and reports ACK/NACK over SPI.
module puf_session_ctrl #(
    parameter int          RESP_BYTES = 32,
    parameter int          TIMEOUT    = 1023,
    parameter logic [7:0]  CMD_CHALL  = 8'h01,
    parameter logic [7:0]  ACK        = 8'h55,
    parameter logic [7:0]  NACK       = 8'hAA
) (
    input  logic                      w_clk,
    input  logic                      n_rst,
    input  logic                      go,
    output logic [7:0]                spi_tx_byte,
    output logic                      spi_tx_dv,
    input  logic                      spi_tx_ready,
    input  logic                      spi_rx_dv,
    input  logic [7:0]                spi_rx_byte,
    output logic                      puf_start,
    output logic [7:0]                puf_challenge,
    input  logic                      puf_done,
    input  logic [RESP_BYTES*8-1:0]   puf_response,
    output logic                      val_start,
    input  logic                      val_valid,
    output logic [7:0]                mem_addr,
    output logic [7:0]                mem_data,
    output logic                      mem_we,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int RW = RESP_BYTES * 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD      = 3'd1,
        S_DUMMY    = 3'd2,
        S_PUF_RUN  = 3'd3,
        S_VALIDATE = 3'd4,
        S_STORE    = 3'd5,
        S_REPORT   = 3'd6,
        S_WAIT_RPT = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic            sent_q, sent_d;
    logic [10:0]     cnt_q, cnt_d;
    logic            vph_q, vph_d;
    logic [7:0]      idx_q, idx_d;
    logic [RW-1:0]   resp_q, resp_d;
    logic [7:0]      chal_q, chal_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic [RW-1:0]   resp_shift_s;

    // State and datapath registers
    always_ff @(posedge w_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            sent_q    <= 1'b0;
            cnt_q     <= 11'd0;
            vph_q     <= 1'b0;
            idx_q     <= 8'd0;
            resp_q    <= '0;
            chal_q    <= 8'h00;
            tx_byte_q <= 8'h00;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sent_q    <= sent_d;
            cnt_q     <= cnt_d;
            vph_q     <= vph_d;
            idx_q     <= idx_d;
            resp_q    <= resp_d;
            chal_q    <= chal_d;
            tx_byte_q <= tx_byte_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; spi_tx_dv must follow spi_tx_ready in the same cycle
    always_comb begin
        state_d   = state_q;
        sent_d    = sent_q;
        cnt_d     = cnt_q;
        vph_d     = vph_q;
        idx_d     = idx_q;
        resp_d    = resp_q;
        chal_d    = chal_q;
        tx_byte_d = tx_byte_q;
        err_d     = err_q;
        done_d    = 1'b0;
        spi_tx_dv = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d   = S_CMD;
                    err_d     = 1'b0;
                    sent_d    = 1'b0;
                    tx_byte_d = CMD_CHALL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD, S_DUMMY: begin
                // sent_q marks the transfer as outstanding; rx_dv before that is stray
                if (!sent_q) begin
                    if (spi_tx_ready) begin
                        spi_tx_dv = 1'b1;
                        sent_d    = 1'b1;
                    end else begin
                        sent_d = 1'b0;
                    end
                end else if (spi_rx_dv) begin
                    sent_d = 1'b0;
                    if (state_q == S_CMD) begin
                        state_d   = S_DUMMY;
                        tx_byte_d = 8'h00;
                    end else begin
                        state_d = S_PUF_RUN;
                        chal_d  = spi_rx_byte;
                        cnt_d   = 11'd0;
                    end
                end else begin
                    sent_d = 1'b1;
                end
            end
            S_PUF_RUN: begin
                cnt_d = cnt_q + 11'd1;
                if (puf_done) begin
                    resp_d  = puf_response;
                    vph_d   = 1'b0;
                    state_d = S_VALIDATE;
                end else if (cnt_q == 11'(TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    tx_byte_d = NACK;
                    state_d   = S_REPORT;
                end else begin
                    state_d = S_PUF_RUN;
                end
            end
            S_VALIDATE: begin
                if (!vph_q) begin
                    vph_d = 1'b1;
                end else if (val_valid) begin
                    idx_d   = 8'd0;
                    state_d = S_STORE;
                end else begin
                    err_d     = 1'b1;
                    tx_byte_d = NACK;
                    state_d   = S_REPORT;
                end
            end
            S_STORE: begin
                if (idx_q == 8'(RESP_BYTES - 1)) begin
                    tx_byte_d = ACK;
                    state_d   = S_REPORT;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            S_REPORT: begin
                if (spi_tx_ready) begin
                    spi_tx_dv = 1'b1;
                    state_d   = S_WAIT_RPT;
                end else begin
                    state_d = S_REPORT;
                end
            end
            S_WAIT_RPT: begin
                if (spi_rx_dv) begin
                    done_d  = !err_q;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_RPT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign resp_shift_s  = resp_q >> {idx_q, 3'b000};
    assign spi_tx_byte   = tx_byte_q;
    assign puf_challenge = chal_q;
    assign puf_start     = (state_q == S_PUF_RUN) && (cnt_q == 11'd0);
    assign val_start     = (state_q == S_VALIDATE);
    assign mem_we        = (state_q == S_STORE);
    assign mem_addr      = (state_q == S_STORE) ? idx_q : 8'h00;
    assign mem_data      = (state_q == S_STORE) ? resp_shift_s[7:0] : 8'h00;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_puf_session_ctrl.sv
// Bench for puf_session_ctrl: SPI slave, PUF and validator responders plus a
// session-level reference model, driven from a vector table and random sessions.
module tb_puf_session_ctrl;
    localparam int         RESP_BYTES = 32;
    localparam int         TIMEOUT    = 1023;
    localparam logic [7:0] CMD_CHALL  = 8'h01;
    localparam logic [7:0] ACK_B      = 8'h55;
    localparam logic [7:0] NACK_B     = 8'hAA;

    logic         w_clk = 1'b0;
    logic         n_rst;
    logic         go;
    logic [7:0]   spi_tx_byte;
    logic         spi_tx_dv;
    logic         spi_tx_ready;
    logic         spi_rx_dv;
    logic [7:0]   spi_rx_byte;
    logic         puf_start;
    logic [7:0]   puf_challenge;
    logic         puf_done;
    logic [255:0] puf_response;
    logic         val_start;
    logic         val_valid;
    logic [7:0]   mem_addr;
    logic [7:0]   mem_data;
    logic         mem_we;
    logic         busy;
    logic         done;
    logic         err;

    puf_session_ctrl #(
        .RESP_BYTES(RESP_BYTES), .TIMEOUT(TIMEOUT), .CMD_CHALL(CMD_CHALL),
        .ACK(ACK_B), .NACK(NACK_B)
    ) dut (
        .w_clk(w_clk), .n_rst(n_rst), .go(go),
        .spi_tx_byte(spi_tx_byte), .spi_tx_dv(spi_tx_dv), .spi_tx_ready(spi_tx_ready),
        .spi_rx_dv(spi_rx_dv), .spi_rx_byte(spi_rx_byte),
        .puf_start(puf_start), .puf_challenge(puf_challenge), .puf_done(puf_done),
        .puf_response(puf_response), .val_start(val_start), .val_valid(val_valid),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .busy(busy), .done(done), .err(err)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        logic [7:0] chal;
        int         lat;
        bit         vv;
        int         stall;
        bit         rnd;
        int         spi_lat;
        logic [7:0] rpt;
        int         nwr;
        bit         err;
        bit         dn;
        int         vs;
    } vec_t;

    vec_t tbl[8];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit          outstanding, prev_dv, armed, force_go, active, cfg_rnd, cfg_vvalid;
    int          lat_left, xfer, puf_timer, cfg_lat, cfg_spi_lat, stall_left;
    logic [7:0]  reply[3];
    logic [7:0]  cur_tx;
    logic [255:0] resp;
    logic [7:0]  tx_q[$];
    logic [15:0] wr_q[$];
    int          dones, puf_starts, vs_cycles, vs_run, start_cyc, err_cyc, proto_bad;
    logic        err_after_go, busy_after_go;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    // Session-level reference: outcome follows from latency, verdict and timeout rule.
    function automatic vec_t model(input vec_t v);
        vec_t e;
        bit   to;
        bit   ok;
        e  = v;
        to = (v.lat >= TIMEOUT);
        ok = !to && v.vv;
        e.rpt = ok ? ACK_B : NACK_B;
        e.nwr = ok ? RESP_BYTES : 0;
        e.err = !ok;
        e.dn  = ok;
        e.vs  = to ? 0 : 2;
        return e;
    endfunction

    // One clock: drive responders after the rising edge, observe at the falling edge.
    task automatic cycle();
        @(posedge w_clk);
        #1;
        cyc++;
        spi_rx_dv = 1'b0;
        if (outstanding) begin
            lat_left--;
            if (lat_left <= 0) begin
                spi_rx_dv   = 1'b1;
                spi_rx_byte = (xfer < 3) ? reply[xfer] : 8'h00;
                xfer++;
                outstanding = 1'b0;
            end
        end else if (cfg_rnd && active && $urandom_range(0, 15) == 0) begin
            spi_rx_dv   = 1'b1;
            spi_rx_byte = 8'($urandom);
        end
        puf_done = 1'b0;
        if (armed) begin
            puf_timer--;
            if (puf_timer == 0) begin
                puf_done = 1'b1;
                armed    = 1'b0;
            end
        end
        if (puf_done) puf_response = resp;
        else for (int k = 0; k < 8; k++) puf_response = {puf_response[223:0], 32'($urandom)};
        val_valid = (vs_run == 1) ? cfg_vvalid : !cfg_vvalid;
        if (stall_left > 0) begin
            spi_tx_ready = 1'b0;
            stall_left--;
        end else begin
            spi_tx_ready = cfg_rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (force_go) go = 1'b1;
        else go = cfg_rnd && active && (xfer < 3) && ($urandom_range(0, 7) == 0);

        @(negedge w_clk);
        if (spi_tx_dv) begin
            if (!spi_tx_ready || prev_dv || outstanding) proto_bad++;
            tx_q.push_back(spi_tx_byte);
            cur_tx      = spi_tx_byte;
            outstanding = 1'b1;
            lat_left    = cfg_spi_lat;
        end else if (outstanding && spi_tx_byte !== cur_tx) begin
            proto_bad++;
        end
        prev_dv = spi_tx_dv;
        if (puf_start) begin
            puf_starts++;
            start_cyc = cyc;
            armed     = 1'b1;
            puf_timer = cfg_lat;
        end
        if (val_start) begin
            vs_cycles++;
            vs_run++;
        end else begin
            vs_run = 0;
        end
        if (mem_we) wr_q.push_back({mem_addr, mem_data});
        if (done) dones++;
        if (err && err_cyc < 0 && puf_starts > 0) err_cyc = cyc;
    endtask

    task automatic run_session(input vec_t v, input int abort_idx, output bit aborted);
        int guard;
        int post;
        aborted = 1'b0;
        tx_q.delete();
        wr_q.delete();
        dones = 0; puf_starts = 0; vs_cycles = 0; vs_run = 0;
        err_cyc = -1; start_cyc = 0; proto_bad = 0;
        xfer = 0; outstanding = 1'b0; armed = 1'b0; prev_dv = 1'b0;
        reply[0] = 8'($urandom);
        reply[1] = v.chal;
        reply[2] = 8'($urandom);
        for (int k = 0; k < 8; k++) resp = {resp[223:0], 32'($urandom)};
        cfg_rnd = v.rnd; cfg_vvalid = v.vv; cfg_lat = v.lat; cfg_spi_lat = v.spi_lat;
        stall_left = v.stall + 1;
        force_go = 1'b1;
        cycle();
        force_go = 1'b0;
        active   = 1'b1;
        cycle();
        err_after_go  = err;
        busy_after_go = busy;
        post  = 0;
        guard = 0;
        while (post < 3 && guard < 4000) begin
            cycle();
            guard++;
            if (abort_idx >= 0 && mem_we && mem_addr == 8'(abort_idx)) begin
                aborted = 1'b1;
                break;
            end
            if (xfer >= 3) post++;
        end
        active = 1'b0;
        go     = 1'b0;
        if (!aborted) check("session_bound", 64'(post >= 3), 64'd1);
    endtask

    task automatic check_session(input vec_t e);
        logic [23:0]  txp;
        logic [255:0] sh;
        int           mism;
        txp  = 24'h0;
        mism = 0;
        for (int i = 0; i < tx_q.size() && i < 3; i++) txp = {txp[15:0], tx_q[i]};
        for (int i = 0; i < wr_q.size(); i++) begin
            sh = resp >> (8 * i);
            if (wr_q[i] !== {8'(i), sh[7:0]}) mism++;
        end
        check("err_clr_on_go", 64'(err_after_go), 64'd0);
        check("busy_after_go", 64'(busy_after_go), 64'd1);
        check("tx_count", 64'(tx_q.size()), 64'd3);
        check("tx_bytes", 64'(txp), 64'({CMD_CHALL, 8'h00, e.rpt}));
        check("mem_wr_count", 64'(wr_q.size()), 64'(e.nwr));
        check("mem_wr_content", 64'(mism), 64'd0);
        check("done_pulses", 64'(dones), 64'(e.dn));
        check("err_final", 64'(err), 64'(e.err));
        check("puf_challenge", 64'(puf_challenge), 64'(e.chal));
        check("spi_protocol", 64'(proto_bad), 64'd0);
        check("puf_start_pulses", 64'(puf_starts), 64'd1);
        check("val_start_cycles", 64'(vs_cycles), 64'(e.vs));
        if (e.vs == 0) check("timeout_cycles", 64'(err_cyc - start_cyc), 64'(TIMEOUT));
        check("busy_end", 64'(busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   ab;
        //          chal   lat   vv  stall rnd slat  rpt     nwr err dn vs
        tbl[0] = '{8'h3C,   50, 1'b1,  0, 1'b0, 2, ACK_B,  32, 1'b0, 1'b1, 2};
        tbl[1] = '{8'h3C,   50, 1'b0,  0, 1'b0, 2, NACK_B,  0, 1'b1, 1'b0, 2};
        tbl[2] = '{8'h7E, 2000, 1'b1,  0, 1'b0, 1, NACK_B,  0, 1'b1, 1'b0, 0};
        tbl[3] = '{8'h91, 1022, 1'b1,  0, 1'b0, 1, ACK_B,  32, 1'b0, 1'b1, 2};
        tbl[4] = '{8'h42, 1023, 1'b1,  0, 1'b0, 1, NACK_B,  0, 1'b1, 1'b0, 0};
        tbl[5] = '{8'hC5,    5, 1'b1, 20, 1'b0, 1, ACK_B,  32, 1'b0, 1'b1, 2};
        tbl[6] = '{8'h0F,    1, 1'b1,  3, 1'b1, 3, ACK_B,  32, 1'b0, 1'b1, 2};
        tbl[7] = '{8'hA5,   80, 1'b0,  0, 1'b1, 4, NACK_B,  0, 1'b1, 1'b0, 2};

        n_rst = 1'b1; go = 1'b0; spi_tx_ready = 1'b1; spi_rx_dv = 1'b0; spi_rx_byte = 8'h00;
        puf_done = 1'b0; puf_response = '0; val_valid = 1'b0; resp = '0;
        outstanding = 1'b0; prev_dv = 1'b0; armed = 1'b0; force_go = 1'b0; active = 1'b0;
        cfg_rnd = 1'b0; cfg_vvalid = 1'b0; cfg_lat = 1; cfg_spi_lat = 1; stall_left = 0;
        xfer = 0; lat_left = 0; puf_timer = 0; vs_run = 0; err_cyc = -1;
        #1 n_rst = 1'b0;
        #2;
        check("reset_outputs", 64'({spi_tx_byte, spi_tx_dv, puf_start, puf_challenge, val_start,
              mem_addr, mem_data, mem_we, busy, done, err}), 64'd0);
        repeat (2) @(negedge w_clk);
        n_rst = 1'b1;
        repeat (6) cycle();
        check("idle_no_activity", 64'(tx_q.size() + wr_q.size() + puf_starts + vs_cycles + dones),
              64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_session(tbl[i], -1, ab);
            check_session(tbl[i]);
        end

        for (int r = 0; r < 8; r++) begin
            v.chal    = 8'($urandom);
            v.lat     = ($urandom_range(0, 4) == 0) ? TIMEOUT - 1 + $urandom_range(0, 1)
                                                     : $urandom_range(1, 300);
            v.vv      = $urandom_range(0, 3) != 0;
            v.stall   = $urandom_range(0, 30);
            v.rnd     = 1'b1;
            v.spi_lat = $urandom_range(1, 4);
            v = model(v);
            run_session(v, -1, ab);
            check_session(v);
        end

        // Reset asserted while the store is writing index 10
        run_session(tbl[0], 10, ab);
        check("abort_reached", 64'(ab), 64'd1);
        n_rst = 1'b0;
        #1;
        check("reset_mid_store", 64'({spi_tx_byte, spi_tx_dv, puf_start, puf_challenge, val_start,
              mem_addr, mem_data, mem_we, busy, done, err}), 64'd0);
        outstanding = 1'b0; armed = 1'b0; prev_dv = 1'b0;
        repeat (2) @(negedge w_clk);
        n_rst = 1'b1;
        repeat (3) cycle();
        check("post_reset_idle", 64'(busy), 64'd0);
        run_session(tbl[0], -1, ab);
        check_session(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
